// File: rtl/p2b_counter.sv
// p2b_counter: pulse-stream to binary converter.
// Counts ones on pulsed_in over a window of 2^WINDOW_LOG2 cycles and presents
// the count scaled to WIDTH bits, with a one-cycle valid strobe.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; pulsed_in ignored; outputs hold last result
// COUNT | sampling pulsed_in, one sample per edge, N samples per window
module p2b_counter #(
    parameter int WIDTH       = 16,
    parameter int WINDOW_LOG2 = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cont,
    input  logic                   abort,
    input  logic                   pulsed_in,
    output logic                   busy,
    output logic [WIDTH-1:0]       binary_out,
    output logic                   valid,
    output logic [WINDOW_LOG2:0]   count_raw
);

    localparam int SHIFT = WIDTH - WINDOW_LOG2;

    generate
        if (WINDOW_LOG2 < 1 || WINDOW_LOG2 > WIDTH) begin : g_bad_window
            $error("p2b_counter: WINDOW_LOG2 must be in 1..WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [WINDOW_LOG2:0]   ones_cnt;
    logic                   last_sample;
    logic [WINDOW_LOG2:0]   total;
    logic [WIDTH-1:0]       scaled;

    // The final sample is folded in combinationally so it lands in this window.
    assign last_sample = (state == COUNT) && (win_cnt == {WINDOW_LOG2{1'b1}});
    assign total       = ones_cnt + (WINDOW_LOG2 + 1)'(pulsed_in);
    assign busy        = (state == COUNT);

    // Scale to WIDTH bits; a full window (total == N) cannot be represented, so it saturates.
    always_comb begin
        scaled = WIDTH'(total[WINDOW_LOG2-1:0]) << SHIFT;
        if (total[WINDOW_LOG2]) begin
            scaled = {WIDTH{1'b1}};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: abort dominates both start and window completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_sample && !cont) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window and ones counters; cleared while idle, on abort and at each window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            ones_cnt <= '0;
        end else if (state != COUNT || abort || last_sample) begin
            win_cnt  <= '0;
            ones_cnt <= '0;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            ones_cnt <= total;
        end
    end

    // Result registers and valid strobe; only an unaborted completion updates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            binary_out <= '0;
            count_raw  <= '0;
        end else begin
            valid <= last_sample && !abort;
            if (last_sample && !abort) begin
                binary_out <= scaled;
                count_raw  <= total;
            end
        end
    end

endmodule

// File: tb/tb_p2b_counter.sv
// Testbench for p2b_counter with a 16-cycle window and 16-bit output.
module tb_p2b_counter;

    localparam int WIDTH = 16;
    localparam int WL    = 4;
    localparam int N     = 1 << WL;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cont = 1'b0;
    logic             abort = 1'b0;
    logic             pulsed_in = 1'b0;
    logic             busy;
    logic [WIDTH-1:0] binary_out;
    logic             valid;
    logic [WL:0]      count_raw;

    int errors = 0;
    int checks = 0;

    p2b_counter #(.WIDTH(WIDTH), .WINDOW_LOG2(WL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .abort      (abort),
        .pulsed_in  (pulsed_in),
        .busy       (busy),
        .binary_out (binary_out),
        .valid      (valid),
        .count_raw  (count_raw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: estimate = ones/N * 2^WIDTH, truncated, capped at full scale.
    function automatic logic [WIDTH-1:0] ref_bin(input int ones);
        longint v;
        v = (longint'(ones) * (longint'(1) << WIDTH)) / N;
        if (v > (longint'(1) << WIDTH) - 1) v = (longint'(1) << WIDTH) - 1;
        return WIDTH'(v);
    endfunction

    // One window: pat[i] is the sample taken at edge E(i+1).
    task automatic run_window(input logic [N-1:0] pat, input bit cont_val,
                              input bit do_start, input string tag);
        int ones;
        ones = 0;
        for (int i = 0; i < N; i++) ones += int'(pat[i]);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            pulsed_in = pat[i];
            cont      = cont_val;
            start     = (i < N - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (i < N - 1) begin
                checks++;
                if (valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s mid-window sample %0d: valid=%b busy=%b, required valid=0 busy=1",
                             tag, i + 1, valid, busy);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s valid at completion: got %b required 1", tag, valid);
        end
        checks++;
        if (count_raw !== (WL + 1)'(ones)) begin
            errors++;
            $display("FAIL %s count_raw: got %0d required %0d", tag, count_raw, ones);
        end
        checks++;
        if (binary_out !== ref_bin(ones)) begin
            errors++;
            $display("FAIL %s binary_out: got %h required %h", tag, binary_out, ref_bin(ones));
        end
        checks++;
        if (busy !== cont_val) begin
            errors++;
            $display("FAIL %s busy after completion: got %b required %b", tag, busy, cont_val);
        end
    endtask

    function automatic logic [N-1:0] three_ones();
        logic [N-1:0] p;
        p = '0;
        while ($countones(p) < 3) p[$urandom_range(0, N - 1)] = 1'b1;
        return p;
    endfunction

    task automatic test_reset();
        tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || binary_out !== '0 || count_raw !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b valid=%b bin=%h raw=%0d, required all zero",
                     busy, valid, binary_out, count_raw);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignore();
        pulsed_in = 1'b1;
        abort     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore: busy=%b valid=%b required 0 0", busy, valid);
            end
        end
        abort = 1'b0;
        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort: busy=%b required 0", busy);
        end
        pulsed_in = 1'b0;
    endtask

    task automatic test_one_shot();
        logic [N-1:0] p;
        run_window('0, 1'b0, 1'b1, "zeros");
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got %b required 0", valid);
        end
        run_window(16'h5555, 1'b0, 1'b1, "toggle");
        tick();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL toggle after: valid=%b busy=%b required 0 0", valid, busy);
        end
        run_window(16'hFFFF, 1'b0, 1'b1, "all_ones");
        run_window(16'h8000, 1'b0, 1'b1, "last_only");
        for (int k = 0; k < 6; k++) begin
            p = N'($urandom);
            run_window(p, 1'b0, 1'b1, "random");
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_back_to_back();
        run_window(three_ones(), 1'b1, 1'b1, "cont_w1");
        run_window(three_ones(), 1'b1, 1'b0, "cont_w2");
        run_window(three_ones(), 1'b0, 1'b0, "cont_last");
        cont = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL cont_drop: busy=%b valid=%b required 0 0", busy, valid);
        end
    endtask

    task automatic test_abort();
        run_window(three_ones(), 1'b0, 1'b1, "pre_abort");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pulsed_in = 1'($urandom_range(0, 1));
            abort     = (i == 6);
            tick();
        end
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || binary_out !== 16'h3000 || count_raw !== 5'd3) begin
            errors++;
            $display("FAIL abort_mid: busy=%b valid=%b bin=%h raw=%0d required 0 0 3000 3",
                     busy, valid, binary_out, count_raw);
        end
        for (int i = 0; i < N + 2; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || binary_out !== 16'h3000) begin
                errors++;
                $display("FAIL abort_hold: valid=%b bin=%h required 0 3000", valid, binary_out);
            end
        end
        // abort coinciding with completion
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            pulsed_in = 1'b1;
            abort     = (i == N - 1);
            tick();
        end
        abort     = 1'b0;
        pulsed_in = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || binary_out !== 16'h3000 || count_raw !== 5'd3) begin
            errors++;
            $display("FAIL abort_at_end: valid=%b busy=%b bin=%h raw=%0d required 0 0 3000 3",
                     valid, busy, binary_out, count_raw);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulsed_in = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (binary_out !== '0 || valid !== 1'b0 || busy !== 1'b0 || count_raw !== '0) begin
            errors++;
            $display("FAIL reset_mid: bin=%h valid=%b busy=%b raw=%0d required all zero",
                     binary_out, valid, busy, count_raw);
        end
        tick();
        rst_n     = 1'b1;
        pulsed_in = 1'b0;
        tick();
        run_window(N'($urandom), 1'b0, 1'b1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_one_shot();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/p2b_counter.md
Name: p2b_counter

Overview:
- Stochastic-to-binary converter; the inverse of the binary-to-pulse stochastic converter.
- Counts 1s on a unipolar pulse stream over a fixed window of 2^WINDOW_LOG2 clock cycles.
- Scales the count to a WIDTH-bit binary estimate and presents it with a one-cycle valid strobe.
- Sits at the reservoir readout, decoding node pulse streams back to binary for training and output logic.

Parameters:
- WIDTH, 16: bit width of binary_out.
- WINDOW_LOG2, 16: log2 of the window length in cycles. Legal range 1..WIDTH; elaboration error outside it.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin one conversion window; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at window completion.
- abort  in  1  cancel the current window; no result.
- pulsed_in  in  1  stochastic pulse stream (1 = pulse).
- busy  out  1  high while in COUNT.
- binary_out  out  WIDTH  last completed estimate; held between windows.
- valid  out  1  one-cycle strobe; binary_out updated this cycle.
- count_raw  out  WINDOW_LOG2+1  unscaled 1s count of the last completed window.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, valid=0, binary_out=0, count_raw=0; internal win_cnt=0, ones_cnt=0.
- States: IDLE, COUNT. Let N = 2^WINDOW_LOG2.
- IDLE:
  - start=1 at edge E0 -> COUNT; win_cnt and ones_cnt cleared.
  - pulsed_in is ignored in IDLE.
- COUNT, sampling:
  - Edges E1..EN each sample pulsed_in: ones_cnt += pulsed_in, win_cnt += 1.
  - win_cnt is WINDOW_LOG2 bits, so the last sample is taken when win_cnt == N-1.
  - ones_cnt is WINDOW_LOG2+1 bits and never overflows (maximum N).
- COUNT, completion at edge EN (win_cnt == N-1):
  - total = ones_cnt + pulsed_in, computed combinationally so the last sample is included.
  - count_raw <= total.
  - binary_out <= total << (WIDTH-WINDOW_LOG2), saturating to all-ones when total == N.
  - valid <= 1 for exactly one cycle.
- After completion:
  - cont=1 at EN: stay in COUNT with counters cleared; the next window samples start at EN+1, with no gap cycle.
  - cont=0 at EN: go to IDLE, busy=0.
- Latency: valid is high in the cycle after edge EN, i.e. N cycles after the start edge.
- start in COUNT: ignored.
- abort=1 in COUNT: go to IDLE next edge, counters cleared, no valid; binary_out and count_raw keep their previous values.
- abort together with completion: abort wins, no valid, outputs unchanged.
- abort in IDLE: no effect.
- abort and start both high in IDLE: abort wins, stay in IDLE.
- Reset mid-window: immediate return to IDLE; partial count discarded; outputs zeroed.
- busy = (state == COUNT), registered; goes high the cycle after the start edge.
- Scaling is exact: the estimate equals total/N times 2^WIDTH, truncated; no rounding.

Test Plan:
- WINDOW_LOG2=4, pulsed_in=0 constant, start pulse -> valid exactly 16 cycles after the start edge, binary_out=0x0000, count_raw=0.
- WINDOW_LOG2=4, pulsed_in toggling 1,0,1,0,... -> count_raw=8, binary_out=0x8000; valid high for one cycle only.
- WINDOW_LOG2=4, pulsed_in=1 constant -> count_raw=16, binary_out=0xFFFF (saturated); pulse only on the final sample (15 zeros then 1) -> count_raw=1, binary_out=0x1000.
- WINDOW_LOG2=4, cont=1, pulsed_in with 3 ones per window -> valid every 16 cycles with no gap, binary_out=0x3000 each time; drop cont -> busy low after the next valid.
- Abort asserted at sample 7 after a prior result 0x3000 -> no valid, binary_out stays 0x3000, busy low next cycle; rst_n low at sample 9 of another window -> binary_out=0, valid=0 immediately.
- Default parameters, fed by the binary-to-pulse converter with binary_in=0x4000 -> binary_out within 0x4000 ± 0x0004.
